// File: rtl/grid_view_pkg.sv
// Shared mode encodings and cell indexing for the grid window viewer.
// Pure definitions, no logic.
package grid_view_pkg;

  localparam logic [1:0] MODE_ZERO  = 2'b00;
  localparam logic [1:0] MODE_TORUS = 2'b01;
  localparam logic [1:0] MODE_CLAMP = 2'b10;
  localparam logic [1:0] MODE_TILE  = 2'b11;

  // Cell (x,y) lives at bit y*w+x of a flattened grid word.
  function automatic int idx(input int x, input int y, input int w);
    return y * w + x;
  endfunction

endpackage

// File: rtl/grid_line_shift.sv
// Combinational 1-D shifter over NLINES packed lines of LEN cells: out[i] = in[i+off] under the boundary mode.
// Latency 0; no backpressure (pure function of its inputs).
module grid_line_shift
  import grid_view_pkg::*;
#(
  parameter int LEN    = 32,
  parameter int NLINES = 1,
  parameter int OFF_W  = 4,
  parameter int TILE   = 4
) (
  input  logic [LEN*NLINES-1:0] line_in,
  input  logic [OFF_W-1:0]      off,
  input  logic [1:0]            mode,
  output logic [LEN*NLINES-1:0] line_out
);

  always_comb begin
    int   ofs;
    int   src;
    logic hit;
    line_out = '0;
    ofs      = int'($signed(off));
    src      = 0;
    hit      = 1'b0;
    for (int l = 0; l < NLINES; l++) begin
      for (int i = 0; i < LEN; i++) begin
        src = i + ofs;
        hit = 1'b1;
        case (mode)
          MODE_ZERO:  hit = (src >= 0) && (src < LEN);
          MODE_TORUS: src = src & (LEN - 1);
          MODE_CLAMP: src = (src < 0) ? 0 : ((src >= LEN) ? LEN - 1 : src);
          // Masking (i+ofs) keeps the source inside the cell's own tile.
          MODE_TILE:  src = (i & ~(TILE - 1)) + ((i + ofs) & (TILE - 1));
        endcase
        line_out[l*LEN+i] = hit & line_in[l*LEN + (src & (LEN - 1))];
      end
    end
  end

endmodule

// File: rtl/grid_window_viewer.sv
// Two-stage grid viewer: X shift row-wise into s1, Y shift column-wise into s2.
// Latency 2 cycles; holds output under out_ready=0, buffers 2 words, in_ready is the only comb path.
module grid_window_viewer
  import grid_view_pkg::*;
#(
  parameter int GRID_W = 32,
  parameter int GRID_H = 32,
  parameter int OFF_W  = 4,
  parameter int TILE   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [GRID_W*GRID_H-1:0] in_grid,
  input  logic [OFF_W-1:0]         off_x,
  input  logic [OFF_W-1:0]         off_y,
  input  logic [1:0]               mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [GRID_W*GRID_H-1:0] out_grid,
  output logic [1:0]               out_mode
);

  localparam int N = GRID_W * GRID_H;

  logic             s1_valid, s2_valid;
  logic [N-1:0]     s1_data, s2_data;
  logic [OFF_W-1:0] s1_off_y;
  logic [1:0]       s1_mode, s2_mode;
  logic             s1_load, s2_load;
  logic [N-1:0]     x_shifted, col_in, col_out, y_shifted;

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load && !rst;
  assign out_valid = s2_valid;
  assign out_grid  = s2_data;
  assign out_mode  = s2_mode;

  grid_line_shift #(
    .LEN(GRID_W), .NLINES(GRID_H), .OFF_W(OFF_W), .TILE(TILE)
  ) u_shift_x (
    .line_in (in_grid),
    .off     (off_x),
    .mode    (mode),
    .line_out(x_shifted)
  );

  // Column-major view of s1 so the same line shifter can act along Y.
  for (genvar gx = 0; gx < GRID_W; gx++) begin : g_col
    for (genvar gy = 0; gy < GRID_H; gy++) begin : g_cell
      assign col_in[gx*GRID_H+gy]         = s1_data[idx(gx, gy, GRID_W)];
      assign y_shifted[idx(gx, gy, GRID_W)] = col_out[gx*GRID_H+gy];
    end
  end

  grid_line_shift #(
    .LEN(GRID_H), .NLINES(GRID_W), .OFF_W(OFF_W), .TILE(TILE)
  ) u_shift_y (
    .line_in (col_in),
    .off     (s1_off_y),
    .mode    (s1_mode),
    .line_out(col_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_off_y <= '0;
      s1_mode  <= MODE_ZERO;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_mode  <= MODE_ZERO;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data  <= x_shifted;
          s1_off_y <= off_y;
          s1_mode  <= mode;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= y_shifted;
          s2_mode <= s1_mode;
        end
      end
    end
  end

endmodule

// File: tb/tb_grid_window_viewer.sv
// Scoreboard bench for grid_window_viewer at 8x8, TILE=4, OFF_W=4.
module tb_grid_window_viewer;

  localparam int W = 8, H = 8, OW = 4, T = 4, N = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [N-1:0]  in_grid;
  logic [OW-1:0] off_x, off_y;
  logic [1:0]    mode;
  logic          out_valid, out_ready;
  logic [N-1:0]  out_grid;
  logic [1:0]    out_mode;

  grid_window_viewer #(.GRID_W(W), .GRID_H(H), .OFF_W(OW), .TILE(T)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_grid(in_grid),
    .off_x(off_x), .off_y(off_y), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_grid(out_grid), .out_mode(out_mode)
  );

  always #5 clk = ~clk;

  int           n_vec = 0, n_err = 0;
  logic [65:0]  sb[$];
  logic [N-1:0] last_out;
  logic [65:0]  held;
  bit           stalled_prev = 0;
  bit           rand_bp = 0;
  logic         ready_req = 1'b1;
  logic         rand_bit = 1'b1;

  assign out_ready = rand_bp ? rand_bit : ready_req;

  initial forever begin
    @(posedge clk); #1;
    rand_bit = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int src_of(input int i, input int off, input int len,
                                input logic [1:0] m, output bit ok);
    int s;
    s  = i + off;
    ok = 1;
    case (m)
      2'b00: ok = (s >= 0) && (s < len);
      2'b01: s = ((s % len) + len) % len;
      2'b10: s = (s < 0) ? 0 : ((s > len - 1) ? len - 1 : s);
      2'b11: s = (i / T) * T + ((((i % T) + off) % T + T) % T);
    endcase
    return ok ? s : 0;
  endfunction

  function automatic logic [N-1:0] model(input logic [N-1:0] g, input logic [OW-1:0] ox,
                                         input logic [OW-1:0] oy, input logic [1:0] m);
    logic [N-1:0] e;
    int sx, sy;
    bit okx, oky;
    e = '0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        sx = src_of(x, int'($signed(ox)), W, m, okx);
        sy = src_of(y, int'($signed(oy)), H, m, oky);
        e[y*W+x] = (okx && oky) ? g[sy*W+sx] : 1'b0;
      end
    return e;
  endfunction

  // Transfers happen at the next rising edge; sample here on the falling edge.
  always @(negedge clk) begin
    logic [65:0] e;
    if (rst) begin
      stalled_prev = 0;
    end else begin
      if (in_valid && in_ready)
        sb.push_back({mode, model(in_grid, off_x, off_y, mode)});
      if (stalled_prev && out_valid)
        chk("hold", {out_mode, out_grid}, held);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 66'd1, 66'd0);
        end else begin
          e = sb.pop_front();
          chk("grid", {2'b00, out_grid}, {2'b00, e[63:0]});
          chk("mode", {64'd0, out_mode}, {64'd0, e[65:64]});
          last_out = out_grid;
        end
      end
      stalled_prev = out_valid && !out_ready;
      held = {out_mode, out_grid};
    end
  end

  task automatic send(input logic [N-1:0] g, input logic [OW-1:0] ox,
                      input logic [OW-1:0] oy, input logic [1:0] m);
    in_grid = g; off_x = ox; off_y = oy; mode = m; in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 66'd1, 66'd0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        @(posedge clk); #1;
        return;
      end
    end
    chk("drain_timeout", 66'd1, 66'd0);
  endtask

  task automatic directed(input string tag, input logic [N-1:0] g, input logic [OW-1:0] ox,
                          input logic [OW-1:0] oy, input logic [1:0] m, input logic [N-1:0] exp);
    send(g, ox, oy, m);
    drain();
    chk(tag, {2'b00, last_out}, {2'b00, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] words[4];
    int acc;
    logic ir;

    rst = 1'b1; in_valid = 1'b0; in_grid = '0; off_x = '0; off_y = '0; mode = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {65'd0, out_valid}, 66'd0);
    chk("rst_in_ready", {65'd0, in_ready}, 66'd0);
    chk("rst_out_grid", {2'b00, out_grid}, 66'd0);
    chk("rst_out_mode", {64'd0, out_mode}, 66'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_in_ready", {65'd0, in_ready}, 66'd1);
    @(posedge clk); #1;

    directed("zero_cell",     64'd1 << 27, 4'd1, 4'hE, 2'b00, 64'd1 << 42);
    directed("torus_p1",      64'h81, 4'd1, 4'd0, 2'b01, 64'hC0);
    directed("torus_m8",      64'h81, 4'h8, 4'd0, 2'b01, 64'h81);
    directed("clamp_col",     64'h0101_0101_0101_0101, 4'hD, 4'd0, 2'b10, 64'h0F0F_0F0F_0F0F_0F0F);
    directed("tile_m1",       64'h08, 4'hF, 4'd0, 2'b11, 64'h01);
    directed("zero_big",      64'hFFFF_FFFF_FFFF_FFFF, 4'h8, 4'd0, 2'b00, 64'd0);
    directed("clamp_y_p7",    64'hA5 << 56, 4'd0, 4'd7, 2'b10, 64'hA5A5_A5A5_A5A5_A5A5);
    directed("clamp_y_m8",    64'h3C, 4'd0, 4'h8, 2'b10, 64'h3C3C_3C3C_3C3C_3C3C);
    directed("tile_y_m8",     64'h0123_4567_89AB_CDEF, 4'd0, 4'h8, 2'b11, 64'h0123_4567_89AB_CDEF);

    // Backpressure: only two words fit while the output is stalled.
    words[0] = 64'h1111_0000_2222_0001; words[1] = 64'h0F0F_1234_8000_0003;
    words[2] = 64'hDEAD_BEEF_0000_00FF; words[3] = 64'h8421_8421_8421_8421;
    ready_req = 1'b0; acc = 0;
    in_grid = words[0]; off_x = 4'd1; off_y = 4'd1; mode = 2'b01; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ir = in_ready;
      @(posedge clk); #1;
      if (ir) begin
        acc++;
        if (acc < 4) in_grid = words[acc];
      end
    end
    @(negedge clk);
    chk("bp_accepted", 66'(acc), 66'd2);
    chk("bp_in_ready_low", {65'd0, in_ready}, 66'd0);
    chk("bp_out_valid", {65'd0, out_valid}, 66'd1);
    @(posedge clk); #1;
    ready_req = 1'b1;
    send(words[2], 4'd1, 4'd1, 2'b01);
    send(words[3], 4'd1, 4'd1, 2'b01);
    drain();

    // Throughput: 8 back-to-back words, out_valid on cycles 2..9.
    for (int j = 0; j < 12; j++) begin
      if (j < 8) begin
        in_valid = 1'b1; in_grid = {$urandom, $urandom};
        off_x = 4'($urandom); off_y = 4'($urandom); mode = 2'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (j < 8) chk("tp_in_ready", {65'd0, in_ready}, 66'd1);
      chk("tp_out_valid", {65'd0, out_valid}, (j >= 2 && j < 10) ? 66'd1 : 66'd0);
      @(posedge clk); #1;
    end
    drain();

    rand_bp = 1;
    for (int r = 0; r < 30; r++)
      send({$urandom, $urandom}, 4'($urandom), 4'($urandom), 2'($urandom));
    rand_bp = 0;
    drain();

    // Reset with both stages full discards both words.
    ready_req = 1'b0;
    send(64'hAAAA_5555_AAAA_5555, 4'd2, 4'd0, 2'b00);
    send(64'h1234_5678_9ABC_DEF0, 4'd0, 4'd3, 2'b01);
    @(negedge clk);
    chk("full_in_ready", {65'd0, in_ready}, 66'd0);
    chk("full_out_valid", {65'd0, out_valid}, 66'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_in_ready", {65'd0, in_ready}, 66'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_out_valid", {65'd0, out_valid}, 66'd0);
    chk("mid_rst_out_grid", {2'b00, out_grid}, 66'd0);
    @(posedge clk); #1;
    rst = 1'b0; ready_req = 1'b1;
    @(negedge clk);
    chk("after_rst_out_valid", {65'd0, out_valid}, 66'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_rst_in_ready", {65'd0, in_ready}, 66'd1);
    @(posedge clk); #1;
    chk("sb_empty", 66'(sb.size()), 66'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/grid_window_viewer.md
Name: grid_window_viewer

Overview:
- Parametrised successor to the memory viewer. It takes one bit-grid word from the control memory (GRID_W x GRID_H cells, one bit per cell) and produces a shifted view of it.
- Shifts are signed X/Y offsets with four boundary modes: zero-fill, torus wrap, edge clamp, and tile-local wrap.
- Two-stage pipeline (X shift, then Y shift) with valid/ready handshakes on both sides. Sits between the control memory read ports and the cell-array loaders; one instance per read channel.

Parameters:
- GRID_W, 32, grid width in cells (power of 2, >=4)
- GRID_H, 32, grid height in cells (power of 2, >=4)
- OFF_W, 4, width of the signed offset fields (two's complement)
- TILE, 4, tile edge for tile-wrap mode (power of 2; must divide GRID_W and GRID_H)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  viewer can accept an input word
- in_grid  in  GRID_W*GRID_H  input grid; cell (x,y) at bit y*GRID_W+x
- off_x  in  OFF_W  signed X offset, sampled with in_grid
- off_y  in  OFF_W  signed Y offset, sampled with in_grid
- mode  in  2  boundary mode, sampled with in_grid: 00 zero, 01 torus, 10 clamp, 11 tile
- out_valid  out  1  output view valid
- out_ready  in  1  downstream accepts view
- out_grid  out  GRID_W*GRID_H  shifted view, same bit layout
- out_mode  out  2  mode carried with the word, for debug and downstream tagging

Behaviour:
- Transfer rule: a transfer occurs on a rising edge where valid && ready. off_x, off_y and mode are captured with in_grid and travel with the word. Later changes to those inputs do not affect words already in flight.
- Output mapping: out(x,y) = in(x+off_x, y+off_y), both offsets sign-extended.
- Stage 1 applies the X term, row-wise. Stage 2 applies the Y term, column-wise, using the stage-1 result and the captured off_y.
- Out-of-range source handling by mode:
  - zero: source cell reads as 0.
  - torus: source index taken modulo GRID_W / GRID_H.
  - clamp: source index saturated to [0, GRID-1].
  - tile: source index = tile base + ((local + off) mod TILE), so a shift never crosses a tile border. Offsets are reduced mod TILE.
- Offsets of magnitude >= grid dimension are legal:
  - zero mode gives an all-zero view.
  - clamp mode replicates the edge row or column.
  - torus mode wraps modulo.
- Pipeline registers: s1_valid/s1_data and s2_valid/s2_data. out_valid = s2_valid and out_grid = s2_data, both driven directly from registers.
- Stage advance rules:
  - s2 loads when !s2_valid || out_ready.
  - s1 loads when !s1_valid || (s2 loads).
  - in_ready = (!s1_valid || s2 loads) && !rst. The only combinational path is out_ready -> in_ready.
- Latency: 2 cycles from input transfer to out_valid, with no stalls. Throughput is 1 word/cycle while out_ready=1.
- Backpressure: with out_ready=0, out_grid and out_mode hold stable while out_valid=1. At most 2 words are buffered; in_ready drops once both stages are full. No word is ever dropped or duplicated.
- Simultaneous events: when s2 drains and s1 is refilled on the same edge, both transfers complete.
- Reset:
  - Clears s1_valid and s2_valid; out_valid=0, out_grid=0, out_mode=00, in_ready=0 during reset.
  - Reset asserted mid-stream discards in-flight words.
  - The first in_ready=1 appears in the cycle after rst falls.
- Offsets of the most negative value (e.g. -8 at OFF_W=4) follow the same rules, with no special case.

Decomposition:
- Package grid_view_pkg holds the mode encoding constants (MODE_ZERO, MODE_TORUS, MODE_CLAMP, MODE_TILE) and the cell-index helper function idx(x,y).
- Sub-module grid_line_shift, instantiated once per stage with a line-length parameter, is the purely combinational 1-D shifter implementing the four modes.
- Stage 1 uses GRID_W-length lines and stage 2 uses GRID_H-length lines. The top level holds only the handshake and registers.

Test Plan (config GRID_W=GRID_H=8, TILE=4, OFF_W=4):
- Zero mode, single cell: in_grid with only cell (3,3) set, off_x=+1, off_y=-2 -> after 2 cycles out_grid has only cell (2,5) set, out_mode=00.
- Torus mode: row 0 = 0x81, off_x=+1, off_y=0 -> row 0 = 0xC0. Same input with off_x=-8 -> output identical to input.
- Clamp and tile modes: column 0 set, clamp, off_x=-3 -> cells x=0..3 set in every row. Cell (3,0) set, tile, off_x=-1 -> cell (0,0) set, not (4,0).
- Backpressure: stream 4 words with out_ready=0 -> in_ready falls after 2 accepted. Raise out_ready -> outputs appear in order, none lost, with out_grid stable while stalled.
- Reset mid-stream: rst=1 with both stages full -> next cycle out_valid=0, out_grid=0. After rst falls, in_ready=1 on the following cycle.
- Throughput: 8 back-to-back words with out_ready=1 -> 8 consecutive out_valid cycles starting at cycle 2.
